// File: rtl/lockin_avl_pkg.sv
// Shared types and elaboration helpers for the lock-in result writer.
// LOCKIN_WRITER_HEADER_EN prepends a 32-bit sequence word to every frame.
package lockin_avl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } wr_state_t;

`ifdef LOCKIN_WRITER_HEADER_EN
    localparam int HDR_WORDS = 32'sd1;
`else
    localparam int HDR_WORDS = 32'sd0;
`endif

    // Words per frame: optional header word plus one word per channel.
    function automatic int stride_of(input int num_ch);
        return num_ch + HDR_WORDS;
    endfunction

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 32'sd0;
        rem = value - 32'sd1;
        while (rem > 32'sd0) begin
            res = res + 32'sd1;
            rem = rem >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lockin_frame_addr_gen.sv
// Word/frame counters for the result ring; produces the Avalon word address.
// The frame base steps by STRIDE per frame, so no multiplier is needed.
module lockin_frame_addr_gen
    import lockin_avl_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_WORD = 0,
    parameter int FRAMES    = 16,
    parameter int STRIDE    = 8,
    parameter int WIDX_W    = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     word_accept,
    input  logic                     frame_last,
    output logic [ADDR_W-1:0]        avm_address,
    output logic [WIDX_W-1:0]        word_idx,
    output logic [clog2(FRAMES)-1:0] frame_idx
);
    localparam int FIDX_W = clog2(FRAMES);

    logic [WIDX_W-1:0] word_idx_r;
    logic [FIDX_W-1:0] frame_idx_r;
    logic [ADDR_W-1:0] frame_base_r;
    logic [ADDR_W-1:0] addr_r;

    // Advance word index on each accepted word; step or wrap the frame slot after the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx_r   <= '0;
            frame_idx_r  <= '0;
            frame_base_r <= ADDR_W'(BASE_WORD);
            addr_r       <= ADDR_W'(BASE_WORD);
        end else if (word_accept) begin
            if (frame_last) begin
                word_idx_r <= '0;
                if (frame_idx_r == FIDX_W'(FRAMES - 1)) begin
                    frame_idx_r  <= '0;
                    frame_base_r <= ADDR_W'(BASE_WORD);
                    addr_r       <= ADDR_W'(BASE_WORD);
                end else begin
                    frame_idx_r  <= frame_idx_r + FIDX_W'(1);
                    frame_base_r <= frame_base_r + ADDR_W'(STRIDE);
                    addr_r       <= frame_base_r + ADDR_W'(STRIDE);
                end
            end else begin
                word_idx_r <= word_idx_r + WIDX_W'(1);
                addr_r     <= addr_r + ADDR_W'(1);
            end
        end
    end

    assign avm_address = addr_r;
    assign word_idx    = word_idx_r;
    assign frame_idx   = frame_idx_r;

endmodule

// File: rtl/lockin_result_writer.sv
// Avalon-MM write master: snapshots NUM_CH lock-in results per strobe and writes
// them as one frame into a RAM ring. Optional header word: LOCKIN_WRITER_HEADER_EN.
module lockin_result_writer
    import lockin_avl_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int BASE_WORD = 0,
    parameter int FRAMES    = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_data,
    input  logic                     clr_overrun,
    output logic [ADDR_W-1:0]        avm_address,
    output logic                     avm_write,
    output logic [DATA_W-1:0]        avm_writedata,
    output logic [DATA_W/8-1:0]      avm_byteenable,
    input  logic                     avm_waitrequest,
    output logic                     busy,
    output logic                     frame_done,
    output logic [clog2(FRAMES)-1:0] frame_idx,
    output logic                     overrun
);
    localparam int STRIDE = stride_of(NUM_CH);
    localparam int WIDX_W = clog2(STRIDE + 1);
    localparam int CH_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;

    wr_state_t          state_r;
    logic               write_r;
    logic               done_r;
    logic               overrun_r;
    logic [DATA_W-1:0]  snap_r [NUM_CH];
    logic [DATA_W-1:0]  wdata_r;
    logic [DATA_W-1:0]  first_data_s;
    logic [DATA_W-1:0]  next_data_s;
    logic [WIDX_W-1:0]  word_idx_s;
    logic [WIDX_W-1:0]  next_idx_s;
    logic [CH_W-1:0]    ch_s;
    logic               word_accept_s;
    logic               frame_last_s;
    logic               drop_s;

    assign word_accept_s = write_r & ~avm_waitrequest;
    assign frame_last_s  = (word_idx_s == WIDX_W'(STRIDE - 1));
    assign drop_s        = sample_valid & (state_r == ST_WRITE);

`ifdef LOCKIN_WRITER_HEADER_EN
    logic [DATA_W-1:0] seq_r;

    // Sequence number counts completed frames; it is word 0 of the next frame
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_r <= '0;
        end else if (word_accept_s && frame_last_s) begin
            seq_r <= seq_r + DATA_W'(1);
        end
    end

    assign first_data_s = seq_r;
`else
    // Word 0 is channel 0, taken straight from the strobe since the snapshot loads on the same edge
    assign first_data_s = sample_data[DATA_W-1:0];
`endif

    // Select the snapshot word presented after the current one is accepted
    always_comb begin
        next_idx_s  = word_idx_s + WIDX_W'(1);
        ch_s        = CH_W'(next_idx_s - WIDX_W'(HDR_WORDS));
        next_data_s = '0;
        if (next_idx_s < WIDX_W'(STRIDE)) begin
            next_data_s = snap_r[ch_s];
        end else begin
            next_data_s = '0;
        end
    end

    // Frame FSM with snapshot, write-data, done pulse and sticky overrun
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            write_r   <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
            wdata_r   <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_r[k] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (sample_valid && enable) begin
                        state_r <= ST_WRITE;
                        write_r <= 1'b1;
                        wdata_r <= first_data_s;
                        for (int k = 0; k < NUM_CH; k++) begin
                            snap_r[k] <= sample_data[k*DATA_W +: DATA_W];
                        end
                    end
                end
                ST_WRITE: begin
                    // Outputs only move on acceptance, which keeps them stable under waitrequest
                    if (word_accept_s) begin
                        if (frame_last_s) begin
                            state_r <= ST_IDLE;
                            write_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            wdata_r <= next_data_s;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    write_r <= 1'b0;
                end
            endcase
            if (drop_s) begin
                overrun_r <= 1'b1;
            end else if (clr_overrun) begin
                overrun_r <= 1'b0;
            end
        end
    end

    lockin_frame_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BASE_WORD (BASE_WORD),
        .FRAMES    (FRAMES),
        .STRIDE    (STRIDE),
        .WIDX_W    (WIDX_W)
    ) u_addr_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .word_accept (word_accept_s),
        .frame_last  (frame_last_s),
        .avm_address (avm_address),
        .word_idx    (word_idx_s),
        .frame_idx   (frame_idx)
    );

    assign avm_write      = write_r;
    assign busy           = write_r;
    assign avm_writedata  = wdata_r;
    assign avm_byteenable = {(DATA_W/8){write_r}};
    assign frame_done     = done_r;
    assign overrun        = overrun_r;

endmodule

// File: tb/tb_lockin_result_writer.sv
// Directed bench for lockin_result_writer: a negedge monitor fills a RAM model,
// tasks compare it and the status outputs against hand-derived frame contents.
module tb_lockin_result_writer;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;
`ifdef LOCKIN_WRITER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int STRIDE = NUM_CH + HDR;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     enable = 1'b0;
    logic                     sample_valid = 1'b0;
    logic [NUM_CH*DATA_W-1:0] sample_data = '0;
    logic                     clr_overrun = 1'b0;
    logic                     avm_waitrequest = 1'b0;
    logic [ADDR_W-1:0]        avm_address;
    logic                     avm_write;
    logic [DATA_W-1:0]        avm_writedata;
    logic [DATA_W/8-1:0]      avm_byteenable;
    logic                     busy;
    logic                     frame_done;
    logic [3:0]               frame_idx;
    logic                     overrun;

    int          checks = 0;
    int          failures = 0;
    int          acc_cnt = 0;
    int          wr_cyc = 0;
    int          be_err = 0;
    logic [31:0] exp_seq = 32'd0;
    logic [31:0] mem [0:1023];

    lockin_result_writer dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .clr_overrun     (clr_overrun),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_idx       (frame_idx),
        .overrun         (overrun)
    );

    always #5 clk = ~clk;

    // RAM slave model: a word is stored whenever the next edge will accept it
    always @(negedge clk) begin
        if (avm_write) begin
            wr_cyc = wr_cyc + 1;
            if (avm_byteenable !== 4'hF) be_err = be_err + 1;
            if (!avm_waitrequest) begin
                mem[avm_address] = avm_writedata;
                acc_cnt = acc_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] pat, input logic [31:0] seq, input int w);
        if (w < HDR) return seq;
        return pat + 32'(w - HDR);
    endfunction

    task automatic strobe(input logic [31:0] pat);
        sample_data = '0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            sample_data = {sample_data[NUM_CH*DATA_W-DATA_W-1:0], pat + 32'(k)};
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_seq = 32'd0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({avm_write, busy, frame_done, overrun, frame_idx, avm_address, avm_writedata, avm_byteenable} !== 54'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h, want 0", {avm_write, busy, frame_done, overrun, frame_idx, avm_address, avm_writedata, avm_byteenable});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_seq = 32'd0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || avm_write !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b write=%b, want 0/0", busy, avm_write);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_no_stall();
        acc_cnt = 0; wr_cyc = 0; enable = 1'b1;
        strobe(32'h1000_0000);
        for (int i = 0; i < 40 && frame_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (frame_done !== 1'b1) begin failures++; $display("FAIL t1_done: frame_done=%b, want 1", frame_done); end
        checks++;
        if (acc_cnt != STRIDE) begin failures++; $display("FAIL t1_accepts: got %0d, want %0d", acc_cnt, STRIDE); end
        checks++;
        if (wr_cyc != STRIDE) begin failures++; $display("FAIL t1_write_cycles: got %0d, want %0d", wr_cyc, STRIDE); end
        checks++;
        if (frame_idx !== 4'd1 || busy !== 1'b0) begin
            failures++; $display("FAIL t1_idx_busy: idx=%0d busy=%b, want 1/0", frame_idx, busy);
        end
        for (int w = 0; w < STRIDE; w++) begin
            checks++;
            if (mem[10'(w)] !== exp_word(32'h1000_0000, exp_seq, w)) begin
                failures++; $display("FAIL t1_data[%0d]: got %h, want %h", w, mem[10'(w)], exp_word(32'h1000_0000, exp_seq, w));
            end
        end
        exp_seq++;
        @(negedge clk);
        checks++;
        if (frame_done !== 1'b0) begin failures++; $display("FAIL t1_done_pulse: frame_done=%b, want 0", frame_done); end
        checks++;
        if (be_err != 0) begin failures++; $display("FAIL t1_byteenable: %0d bad cycles, want 0", be_err); end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        int  base;
        bit  found;
        base = STRIDE;
        found = 1'b0;
        acc_cnt = 0;
        strobe(32'h2000_0000);
        for (int i = 0; i < 20 && !found; i++) begin
            if (avm_write && avm_address == 10'(base + 2)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL t2_reach_word2: addr=%0d, want %0d", avm_address, base + 2); end
        avm_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (avm_write !== 1'b1 || avm_address !== 10'(base + 2) || avm_writedata !== exp_word(32'h2000_0000, exp_seq, 2)) begin
                failures++;
                $display("FAIL t2_hold[%0d]: write=%b addr=%0d data=%h, want 1/%0d/%h", i, avm_write, avm_address,
                         avm_writedata, base + 2, exp_word(32'h2000_0000, exp_seq, 2));
            end
        end
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 40 && frame_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (frame_done !== 1'b1 || acc_cnt != STRIDE || frame_idx !== 4'd2) begin
            failures++; $display("FAIL t2_complete: done=%b accepts=%0d idx=%0d, want 1/%0d/2", frame_done, acc_cnt, frame_idx, STRIDE);
        end
        for (int w = 0; w < STRIDE; w++) begin
            checks++;
            if (mem[10'(base + w)] !== exp_word(32'h2000_0000, exp_seq, w)) begin
                failures++; $display("FAIL t2_data[%0d]: got %h, want %h", w, mem[10'(base + w)], exp_word(32'h2000_0000, exp_seq, w));
            end
        end
        exp_seq++;
        @(posedge clk); #1;
    endtask

    task automatic test_ring_wrap();
        apply_reset();
        enable = 1'b1;
        for (int f = 0; f < 17; f++) begin
            checks++;
            if (frame_idx !== 4'(f % 16)) begin failures++; $display("FAIL t3_idx[%0d]: got %0d, want %0d", f, frame_idx, f % 16); end
            strobe(32'h3000_0000 + (32'(f) << 8));
            repeat (11) @(posedge clk);
            #1;
        end
        checks++;
        if (frame_idx !== 4'd1 || overrun !== 1'b0) begin
            failures++; $display("FAIL t3_final: idx=%0d overrun=%b, want 1/0", frame_idx, overrun);
        end
        for (int w = 0; w < STRIDE; w++) begin
            checks++;
            if (mem[10'(15 * STRIDE + w)] !== exp_word(32'h3000_0F00, 32'd15, w)) begin
                failures++; $display("FAIL t3_slot15[%0d]: got %h, want %h", w, mem[10'(15 * STRIDE + w)], exp_word(32'h3000_0F00, 32'd15, w));
            end
            checks++;
            if (mem[10'(w)] !== exp_word(32'h3000_1000, 32'd16, w)) begin
                failures++; $display("FAIL t3_slot0[%0d]: got %h, want %h", w, mem[10'(w)], exp_word(32'h3000_1000, 32'd16, w));
            end
        end
        checks++;
        if (mem[10'(STRIDE)] !== exp_word(32'h3000_0100, 32'd1, 0)) begin
            failures++; $display("FAIL t3_slot1: got %h, want %h", mem[10'(STRIDE)], exp_word(32'h3000_0100, 32'd1, 0));
        end
        exp_seq = 32'd17;
    endtask

    task automatic test_overrun();
        enable = 1'b0;
        strobe(32'h5555_0000);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL t4_disabled: busy=%b overrun=%b, want 0/0", busy, overrun); end
        @(posedge clk); #1;
        enable = 1'b1;
        acc_cnt = 0;
        strobe(32'h4000_0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        strobe(32'h4444_0000);
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL t4_overrun_set: got %b, want 1", overrun); end
        for (int i = 0; i < 40 && frame_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (acc_cnt != STRIDE) begin failures++; $display("FAIL t4_accepts: got %0d, want %0d", acc_cnt, STRIDE); end
        for (int w = 0; w < STRIDE; w++) begin
            checks++;
            if (mem[10'(STRIDE + w)] !== exp_word(32'h4000_0000, exp_seq, w)) begin
                failures++; $display("FAIL t4_first_frame[%0d]: got %h, want %h", w, mem[10'(STRIDE + w)], exp_word(32'h4000_0000, exp_seq, w));
            end
        end
        exp_seq++;
        @(posedge clk); #1;
        // Clear and drop in the same cycle, with enable falling mid-frame
        acc_cnt = 0;
        strobe(32'h4100_0000);
        @(posedge clk); #1;
        sample_valid = 1'b1; clr_overrun = 1'b1; enable = 1'b0;
        @(posedge clk); #1;
        sample_valid = 1'b0; clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL t4_set_wins: got %b, want 1", overrun); end
        for (int i = 0; i < 40 && frame_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (acc_cnt != STRIDE || frame_idx !== 4'd3) begin
            failures++; $display("FAIL t4_enable_fall: accepts=%0d idx=%0d, want %0d/3", acc_cnt, frame_idx, STRIDE);
        end
        checks++;
        if (mem[10'(2 * STRIDE + STRIDE - 1)] !== exp_word(32'h4100_0000, exp_seq, STRIDE - 1)) begin
            failures++; $display("FAIL t4_c_last: got %h, want %h", mem[10'(2 * STRIDE + STRIDE - 1)], exp_word(32'h4100_0000, exp_seq, STRIDE - 1));
        end
        exp_seq++;
        @(posedge clk); #1;
        enable = 1'b1;
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL t4_clear: got %b, want 0", overrun); end
        // Strobe landing on the last-word acceptance edge
        strobe(32'h4200_0000);
        repeat (STRIDE - 1) @(posedge clk);
        #1;
        sample_valid = 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        checks++;
        if (frame_done !== 1'b1 || overrun !== 1'b1) begin
            failures++; $display("FAIL t4_last_edge_drop: done=%b overrun=%b, want 1/1", frame_done, overrun);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL t4_no_restart: busy=%b, want 0", busy); end
        exp_seq++;
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  found;
        base = 4 * STRIDE;
        found = 1'b0;
        strobe(32'h6000_0000);
        for (int i = 0; i < 20 && !found; i++) begin
            if (avm_write && avm_address == 10'(base + 5)) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL t5_reach_word5: addr=%0d, want %0d", avm_address, base + 5); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (avm_write !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL t5_async_drop: write=%b busy=%b, want 0/0", avm_write, busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_seq = 32'd0;
        checks++;
        if (frame_idx !== 4'd0) begin failures++; $display("FAIL t5_idx_restart: got %0d, want 0", frame_idx); end
        acc_cnt = 0;
        strobe(32'h7000_0000);
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 10'd0) begin
            failures++; $display("FAIL t5_first_addr: write=%b addr=%0d, want 1/0", avm_write, avm_address);
        end
        for (int i = 0; i < 40 && frame_done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (acc_cnt != STRIDE || frame_idx !== 4'd1) begin
            failures++; $display("FAIL t5_frame: accepts=%0d idx=%0d, want %0d/1", acc_cnt, frame_idx, STRIDE);
        end
        for (int w = 0; w < STRIDE; w++) begin
            checks++;
            if (mem[10'(w)] !== exp_word(32'h7000_0000, exp_seq, w)) begin
                failures++; $display("FAIL t5_data[%0d]: got %h, want %h", w, mem[10'(w)], exp_word(32'h7000_0000, exp_seq, w));
            end
        end
        exp_seq++;
        @(posedge clk); #1;
    endtask

`ifdef LOCKIN_WRITER_HEADER_EN
    task automatic test_header();
        apply_reset();
        enable = 1'b1;
        strobe(32'h8000_0000);
        repeat (11) @(posedge clk);
        #1;
        strobe(32'h8100_0000);
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (mem[10'd0] !== 32'd0 || mem[10'd9] !== 32'd1) begin
            failures++; $display("FAIL t6_seq: got %h/%h, want 0/1", mem[10'd0], mem[10'd9]);
        end
        checks++;
        if (mem[10'd1] !== 32'h8000_0000 || mem[10'd10] !== 32'h8100_0000) begin
            failures++; $display("FAIL t6_ch0: got %h/%h, want 80000000/81000000", mem[10'd1], mem[10'd10]);
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 1024; a++) mem[a] = 32'd0;
        test_reset();
        test_no_stall();
        test_stall();
        test_ring_wrap();
        test_overrun();
        test_reset_mid();
`ifdef LOCKIN_WRITER_HEADER_EN
        test_header();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
